// File: rtl/perm_iter.sv
// rtl/perm_iter.sv - iterated nibble-permutation / lane-rotation engine
`timescale 1ns/1ps
module perm_iter #(
    parameter int LANES = 1,
    parameter int RW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [32*LANES-1:0]   din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  mode,
    input  logic [RW-1:0]         rounds,
    output logic [32*LANES-1:0]   dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [32*LANES-1:0]   work_q, work_d;
    logic [RW-1:0]         cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [32*LANES-1:0]   perm;
    logic [32*LANES-1:0]   rnd;

    // Output nibbles 7..0 taken from input nibbles {7,4,3,0,5,6,1,2}
    function automatic logic [31:0] fwd_lane(input logic [31:0] x);
        return {x[31:28], x[19:16], x[15:12], x[3:0],
                x[23:20], x[27:24], x[7:4],   x[11:8]};
    endfunction

    // Output nibbles 7..0 taken from input nibbles {7,2,3,6,5,0,1,4}
    function automatic logic [31:0] inv_lane(input logic [31:0] x);
        return {x[31:28], x[11:8], x[15:12], x[27:24],
                x[23:20], x[3:0],  x[7:4],   x[19:16]};
    endfunction

    // One round of the job's direction applied to the working register
    always_comb begin
        perm = '0;
        rnd  = '0;
        if (!mode_q) begin
            // Forward: permute every lane, then rotate lanes up by one
            for (int i = 0; i < LANES; i++)
                perm[32*i +: 32] = fwd_lane(work_q[32*i +: 32]);
            for (int i = 0; i < LANES; i++)
                rnd[32*i +: 32] = perm[32*((i + LANES - 1) % LANES) +: 32];
        end else begin
            // Inverse: rotate lanes down by one, then un-permute every lane
            for (int i = 0; i < LANES; i++)
                perm[32*i +: 32] = work_q[32*((i + 1) % LANES) +: 32];
            for (int i = 0; i < LANES; i++)
                rnd[32*i +: 32] = inv_lane(perm[32*i +: 32]);
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    work_d = din;
                    mode_d = mode;
                    cnt_d  = rounds;
                    if (rounds == '0) state_d = DONE;
                    else              state_d = RUN;
                end
            end
            RUN: begin
                work_d = rnd;
                cnt_d  = cnt_q - RW'(1);
                if (cnt_q == RW'(1)) state_d = DONE;
            end
            DONE: begin
                // Returning to IDLE here means no accept can share this edge
                if (dout_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign din_ready  = (state_q == IDLE) && rst_n;
    assign dout_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign dout       = work_q;

endmodule

// File: tb/tb_perm_iter.sv
// tb/tb_perm_iter.sv - scoreboard bench for perm_iter
`timescale 1ns/1ps
module tb_perm_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        mode;
    logic [3:0]  rounds;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;

    logic [63:0] din2;
    logic        din_valid2;
    logic        din_ready2;
    logic        mode2;
    logic [3:0]  rounds2;
    logic [63:0] dout2;
    logic        dout_valid2;
    logic        dout_ready2;
    logic        busy2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit stall_on = 0;

    perm_iter #(.LANES(1), .RW(4)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .mode(mode), .rounds(rounds), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
    );

    perm_iter #(.LANES(2), .RW(4)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .din_valid(din_valid2),
        .din_ready(din_ready2), .mode(mode2), .rounds(rounds2), .dout(dout2),
        .dout_valid(dout_valid2), .dout_ready(dout_ready2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model, table driven: src[k] = input nibble feeding output nibble k
    function automatic logic [31:0] model(input logic [31:0] d, input bit m, input int r);
        int fsrc[8] = '{2, 1, 6, 5, 0, 3, 4, 7};
        int isrc[8] = '{4, 1, 0, 5, 6, 3, 2, 7};
        logic [31:0] x = d;
        logic [31:0] y;
        for (int n = 0; n < r; n++) begin
            for (int k = 0; k < 8; k++)
                y[4*k +: 4] = m ? x[4*isrc[k] +: 4] : x[4*fsrc[k] +: 4];
            x = y;
        end
        return x;
    endfunction

    // Monitor: every completed output handshake is checked against the scoreboard
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected actual=%h expected=none", dout);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL sb_data actual=%h expected=%h", dout, e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit m, input logic [3:0] r, input bit push);
        int n = 0;
        while (!din_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) chk("din_ready_timeout", 0, 1);
        din = d; mode = m; rounds = r; din_valid = 1'b1;
        if (push) exp_q.push_back(model(d, m, int'(r)));
        @(posedge clk); #1;
        din_valid = 1'b0;
        din = $urandom; mode = 1'($urandom); rounds = 4'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_left", 64'(exp_q.size()), 0);
    endtask

    task automatic job(input logic [31:0] d, input bit m, input logic [3:0] r, input logic [31:0] exp);
        int cnt = 0;
        chk("model_vs_hand", model(d, m, int'(r)), exp);
        send(d, m, r, 1'b1);
        while (!dout_valid && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        chk("latency", 64'(cnt), 64'(r));
        wait_drain();
    endtask

    task automatic job2(input logic [63:0] d, input bit m, input logic [63:0] exp);
        int n = 0;
        din2 = d; mode2 = m; rounds2 = 4'd1; din_valid2 = 1'b1;
        @(posedge clk); #1;
        din_valid2 = 1'b0; din2 = '0;
        while (!dout_valid2 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("lanes2_latency", 64'(n), 1);
        chk("lanes2_data", dout2, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 0; mode = 0; rounds = '0; dout_ready = 1'b1;
        din2 = '0; din_valid2 = 0; mode2 = 0; rounds2 = '0; dout_ready2 = 1'b1;
        #2;
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din_ready", din_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_din_ready", din_ready, 1);

        job(32'h76543210, 1'b0, 4'd1, 32'h74305612);
        job(32'h76543210, 1'b0, 4'd2, 32'h70523416);
        job(32'h74305612, 1'b1, 4'd1, 32'h76543210);
        job(32'h70523416, 1'b1, 4'd2, 32'h76543210);
        job(32'hA5C3E19B, 1'b0, 4'd4, 32'hA5C3E19B);
        job(32'h13579BDF, 1'b1, 4'd4, 32'h13579BDF);

        job2(64'h00000000_76543210, 1'b0, 64'h74305612_00000000);
        job2(64'h74305612_00000000, 1'b1, 64'h00000000_76543210);

        // Zero rounds with a stalled consumer: result must hold
        dout_ready = 1'b0;
        send(32'hDEADBEEF, 1'b0, 4'd0, 1'b1);
        chk("r0_valid_now", dout_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_dout", dout, 32'hDEADBEEF);
            chk("hold_valid", dout_valid, 1);
            chk("hold_din_ready", din_ready, 0);
        end
        dout_ready = 1'b1;
        wait_drain();
        chk("after_handshake_idle", busy, 0);

        // Reset in the middle of a 15-round job
        send(32'h76543210, 1'b0, 4'd15, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrun_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_run_dout", dout, 0);
        chk("rst_run_valid", dout_valid, 0);
        chk("rst_run_busy", busy, 0);
        chk("rst_run_din_ready", din_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_din_ready", din_ready, 1);
        chk("rel_dout_valid", dout_valid, 0);
        job(32'h76543210, 1'b0, 4'd1, 32'h74305612);

        // Random back-to-back jobs with consumer stalls
        stall_on = 1;
        fork
            begin
                for (int j = 0; j < 40; j++)
                    send($urandom, 1'($urandom), 4'($urandom_range(0, 15)), 1'b1);
                stall_on = 0;
            end
            begin
                while (stall_on) begin
                    dout_ready = 1'($urandom);
                    @(posedge clk); #1;
                end
                dout_ready = 1'b1;
            end
        join
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
